// File: rtl/uart_tx_scheduler.sv
// uart_tx_scheduler: round-robin share of one UART byte stream among NREQ requesters, each packet followed by its CRC-16 (MSB byte first)
module uart_tx_scheduler #(
  parameter int NREQ = 4,
  parameter int LEN_W = 8,
  parameter logic [15:0] CRC_POLY = 16'h1021,
  parameter logic [15:0] CRC_INIT = 16'hFFFF
) (
  input  logic                   a,
  input  logic                   b,
  input  logic [NREQ-1:0]        req_valid,
  input  logic [NREQ*LEN_W-1:0]  req_len,
  input  logic [NREQ*8-1:0]      req_data,
  output logic [NREQ-1:0]        req_ready,
  output logic [NREQ-1:0]        grant,
  output logic                   busy,
  output logic [7:0]             tx_data,
  output logic                   tx_valid,
  input  logic                   tx_ready,
  output logic [15:0]            crc_out,
  output logic                   crc_done
);
  localparam int IW = $clog2(NREQ);
  typedef enum logic [1:0] {IDLE, PAYLOAD, CRC_HI, CRC_LO} state_t;
  state_t state;
  logic [IW-1:0] rr_ptr, g, pick;
  logic [IW:0] s;
  logic found;
  logic [LEN_W-1:0] cnt, pick_len;
  logic [15:0] crc;
  logic [7:0] cur_byte;
  function automatic logic [15:0] crc_byte(input logic [15:0] c, input logic [7:0] d);
    logic [15:0] r;
    r = c ^ {d, 8'h00};
    for (int i = 0; i < 8; i++) r = r[15] ? (r << 1) ^ CRC_POLY : r << 1;
    return r;
  endfunction
  // Scan downward so the last hit is the nearest requester at or after rr_ptr.
  always_comb begin
    found = 1'b0;
    pick = '0;
    s = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      s = {1'b0, rr_ptr} + (IW+1)'(k);
      s = s >= (IW+1)'(NREQ) ? s - (IW+1)'(NREQ) : s;
      if (req_valid[s[IW-1:0]]) begin
        found = 1'b1;
        pick = s[IW-1:0];
      end
    end
  end
  assign pick_len  = LEN_W'(req_len >> (pick * LEN_W));
  assign cur_byte  = 8'(req_data >> (g * 8));
  assign busy      = state != IDLE;
  assign tx_valid  = state != IDLE;
  assign tx_data   = state == PAYLOAD ? cur_byte : state == CRC_HI ? crc[15:8] : state == CRC_LO ? crc[7:0] : 8'h00;
  assign req_ready = (state == PAYLOAD && tx_ready) ? grant : '0;
  always_ff @(posedge a or posedge b)
    if (b) begin
      state    <= IDLE;
      rr_ptr   <= '0;
      g        <= '0;
      grant    <= '0;
      cnt      <= '0;
      crc      <= '0;
      crc_out  <= '0;
      crc_done <= 1'b0;
    end else begin
      crc_done <= 1'b0;
      case (state)
        IDLE: if (found) begin
          g     <= pick;
          grant <= NREQ'(1) << pick;
          cnt   <= pick_len;
          crc   <= CRC_INIT;
          state <= pick_len != '0 ? PAYLOAD : CRC_HI;
        end
        PAYLOAD: if (tx_ready) begin
          crc <= crc_byte(crc, cur_byte);
          cnt <= cnt - 1'b1;
          if (cnt == LEN_W'(1)) state <= CRC_HI;
        end
        CRC_HI: if (tx_ready) state <= CRC_LO;
        CRC_LO: if (tx_ready) begin
          state    <= IDLE;
          grant    <= '0;
          crc_out  <= crc;
          crc_done <= 1'b1;
          rr_ptr   <= g == IW'(NREQ - 1) ? '0 : g + 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_uart_tx_scheduler.sv
// tb_uart_tx_scheduler: scoreboard bench; requester models feed packets, an offline arbiter/CRC model predicts the byte stream
module tb_uart_tx_scheduler;
  localparam int NREQ = 4;
  localparam int LEN_W = 8;
  logic a = 1'b0;
  logic b = 1'b1;
  logic [NREQ-1:0] req_valid, req_ready, grant;
  logic [NREQ*LEN_W-1:0] req_len;
  logic [NREQ*8-1:0] req_data;
  logic busy, tx_valid, tx_ready, crc_done;
  logic [7:0] tx_data;
  logic [15:0] crc_out;

  uart_tx_scheduler #(.NREQ(NREQ), .LEN_W(LEN_W)) dut (
    .a(a), .b(b), .req_valid(req_valid), .req_len(req_len), .req_data(req_data),
    .req_ready(req_ready), .grant(grant), .busy(busy), .tx_data(tx_data),
    .tx_valid(tx_valid), .tx_ready(tx_ready), .crc_out(crc_out), .crc_done(crc_done)
  );

  always #5 a = ~a;

  typedef struct { logic [7:0] d; logic [NREQ-1:0] g; bit pay; } exp_t;
  exp_t exp_q[$];
  exp_t e;
  logic [15:0] crc_q[$];
  int pend_len [NREQ][$];
  logic [7:0] pend_byte [NREQ][$];
  logic [7:0] cur [NREQ][$];
  int m_len [NREQ][$];
  logic [7:0] m_byte [NREQ][$];
  int rr_m = 0, checks = 0, errors = 0, pulses = 0, gcyc = 0, xfers = 0, ready_pct = 100, stall = 0;
  logic [NREQ-1:0] gprev = '0, rr_seen = '0;
  logic pv = 1'b0, pr = 1'b0, prev_done = 1'b0;
  logic [7:0] pd = 8'h00;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Bit-serial LFSR form of CRC-16-CCITT, one data bit at a time, MSB first
  function automatic logic [15:0] ref_crc(input logic [7:0] d[$]);
    logic [15:0] c;
    logic fb;
    c = 16'hFFFF;
    foreach (d[j])
      for (int k = 7; k >= 0; k--) begin
        fb = c[15] ^ d[j][k];
        c = {c[14:0], 1'b0} ^ (fb ? 16'h1021 : 16'h0000);
      end
    return c;
  endfunction

  task automatic load_pkt(input int i, input logic [7:0] d[$]);
    pend_len[i].push_back(d.size());
    m_len[i].push_back(d.size());
    foreach (d[j]) begin
      pend_byte[i].push_back(d[j]);
      m_byte[i].push_back(d[j]);
    end
  endtask

  task automatic load_rand(input int i, input int n);
    logic [7:0] d[$];
    for (int j = 0; j < n; j++) d.push_back(8'($urandom));
    load_pkt(i, d);
  endtask

  // Offline arbitration: nearest requester with packets left, starting at the model pointer
  task automatic run_model();
    int w, n;
    logic [7:0] d[$];
    logic [15:0] c;
    exp_t x;
    while (1) begin
      w = -1;
      for (int k = 0; k < NREQ; k++)
        if (w < 0 && m_len[(rr_m + k) % NREQ].size() != 0) w = (rr_m + k) % NREQ;
      if (w < 0) break;
      n = m_len[w].pop_front();
      d = {};
      repeat (n) d.push_back(m_byte[w].pop_front());
      x.g = NREQ'(1) << w;
      x.pay = 1'b1;
      foreach (d[j]) begin
        x.d = d[j];
        exp_q.push_back(x);
      end
      c = ref_crc(d);
      x.pay = 1'b0;
      x.d = c[15:8];
      exp_q.push_back(x);
      x.d = c[7:0];
      exp_q.push_back(x);
      crc_q.push_back(c);
      rr_m = (w + 1) % NREQ;
    end
  endtask

  task automatic clear_all();
    exp_q.delete();
    crc_q.delete();
    for (int i = 0; i < NREQ; i++) begin
      pend_len[i].delete();
      pend_byte[i].delete();
      cur[i].delete();
      m_len[i].delete();
      m_byte[i].delete();
    end
    rr_m = 0;
    stall = 0;
  endtask

  task automatic do_reset();
    b = 1'b1;
    clear_all();
    req_valid = '0;
    @(posedge a);
    #2 b = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || crc_q.size() != 0) && n < budget) begin
      @(posedge a);
      n++;
    end
    if (exp_q.size() != 0 || crc_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL timeout actual=%0d_bytes_pending required=0", exp_q.size());
      do_reset();
    end
    repeat (2) @(posedge a);
  endtask

  // Requester and serialiser stimulus, driven just after each rising edge
  always @(posedge a) begin
    #1;
    if (b) begin
      req_valid = '0;
      gprev = '0;
      rr_seen = '0;
    end else begin
      for (int i = 0; i < NREQ; i++) begin
        if (rr_seen[i] && cur[i].size() != 0) void'(cur[i].pop_front());
        if (grant[i] && !gprev[i] && pend_len[i].size() != 0)
          repeat (pend_len[i].pop_front()) cur[i].push_back(pend_byte[i].pop_front());
        req_valid[i] = pend_len[i].size() != 0;
        req_len[i*LEN_W +: LEN_W] = pend_len[i].size() != 0 ? LEN_W'(pend_len[i][0]) : LEN_W'($urandom);
        req_data[i*8 +: 8] = cur[i].size() != 0 ? cur[i][0] : 8'($urandom);
      end
      gprev = grant;
      rr_seen = '0;
      if (stall > 0) begin
        tx_ready = 1'b0;
        stall--;
      end else tx_ready = $urandom_range(99) < ready_pct;
    end
  end

  // Monitor: mid-cycle sampling, pops the scoreboard on every transfer and every crc_done
  always @(negedge a) begin
    if (b) begin
      pv = 1'b0;
      prev_done = 1'b0;
    end else begin
      rr_seen = req_ready;
      pulses += $countones(req_ready);
      if (grant != '0) gcyc++;
      if (pv && !pr) begin
        chk("hold_valid", 32'(tx_valid), 32'd1);
        chk("hold_data", 32'(tx_data), 32'(pd));
      end
      if (tx_valid && tx_ready) begin
        xfers++;
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_byte actual=%0h required=none", tx_data);
        end else begin
          e = exp_q.pop_front();
          chk("tx_data", 32'(tx_data), 32'(e.d));
          chk("grant", 32'(grant), 32'(e.g));
          chk("req_ready", 32'(req_ready), e.pay ? 32'(e.g) : 32'd0);
        end
      end else chk("ready_idle", 32'(req_ready), 32'd0);
      if (crc_done) begin
        chk("done_idle", 32'({busy, grant}), 32'd0);
        if (crc_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_done actual=%0h required=none", crc_out);
        end else chk("crc_out", 32'(crc_out), 32'(crc_q.pop_front()));
      end
      if (prev_done && exp_q.size() != 0) chk("one_bubble", 32'(busy), 32'd1);
      prev_done = crc_done;
      pv = tx_valid;
      pr = tx_ready;
      pd = tx_data;
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] d[$];
    int x0, n;
    tx_ready = 1'b0;
    req_valid = '0;
    req_len = '0;
    req_data = '0;
    repeat (2) @(posedge a);
    #2;
    chk("rst_grant", 32'(grant), 32'd0);
    chk("rst_req_ready", 32'(req_ready), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_tx_valid", 32'(tx_valid), 32'd0);
    chk("rst_tx_data", 32'(tx_data), 32'd0);
    chk("rst_crc_out", 32'(crc_out), 32'd0);
    chk("rst_crc_done", 32'(crc_done), 32'd0);
    b = 1'b0;

    @(posedge a);
    #2;
    d = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39};
    load_pkt(0, d);
    run_model();
    pulses = 0;
    gcyc = 0;
    wait_done(200);
    chk("crc_check_value", 32'(crc_out), 32'h29B1);
    chk("crc_ready_pulses", pulses, 9);
    chk("crc_grant_cycles", gcyc, 11);

    do_reset();
    for (int r = 0; r < 2; r++)
      for (int i = 0; i < NREQ; i++) load_rand(i, 1);
    run_model();
    wait_done(200);

    pulses = 0;
    d = {};
    load_pkt(2, d);
    run_model();
    wait_done(50);
    chk("zero_len_crc", 32'(crc_out), 32'hFFFF);
    chk("zero_len_pulses", pulses, 0);

    load_rand(3, 4);
    run_model();
    x0 = xfers;
    n = 0;
    while (xfers < x0 + 2 && n < 100) begin
      @(negedge a);
      n++;
    end
    stall = 5;
    wait_done(200);

    load_rand(1, 9);
    run_model();
    x0 = xfers;
    n = 0;
    while (xfers < x0 + 3 && n < 100) begin
      @(negedge a);
      n++;
    end
    @(posedge a);
    #2 b = 1'b1;
    #1;
    chk("midrst_grant", 32'(grant), 32'd0);
    chk("midrst_tx_valid", 32'(tx_valid), 32'd0);
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_crc_out", 32'(crc_out), 32'd0);
    clear_all();
    req_valid = '0;
    @(posedge a);
    #2 b = 1'b0;
    load_rand(0, 2);
    load_rand(1, 2);
    run_model();
    n = 0;
    while (grant == '0 && n < 20) begin
      @(negedge a);
      n++;
    end
    chk("first_grant_after_reset", 32'(grant), 32'd1);
    wait_done(200);

    load_rand(3, 255);
    run_model();
    wait_done(400);
    chk("max_len_pulses_seen", 32'(crc_q.size()), 32'd0);

    for (int t = 0; t < 25; t++) begin
      ready_pct = $urandom_range(30, 100);
      for (int i = 0; i < NREQ; i++)
        repeat ($urandom_range(0, 2))
          load_rand(i, $urandom_range(0, 3) == 0 ? $urandom_range(0, 20) : $urandom_range(0, 5));
      run_model();
      wait_done(3000);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
